// File: rtl/control_unit_pipe.sv
// control_unit_pipe
//   RV32I decode control with the ID/EX control register folded in. Decodes
//   the Decode-stage instruction, detects load-use hazards against the
//   instruction currently in Execute, and registers the control word (or a
//   bubble) into the Execute slot. Illegal instructions are flagged and
//   counted in a saturating counter.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active low
//   instr_d      Decode-stage instruction
//   valid_d      instr_d holds a real instruction
//   stall_e      hold the Execute slot
//   flush_e      load a bubble into the Execute slot
//   stall_fd     load-use stall request to IF/ID (combinational)
//   illegal_d    valid_d and instr_d unsupported (combinational)
//   valid_e      Execute slot holds a real instruction
//   RegWriteE .. Rs2E  registered control word and register fields
//   ill_cnt      saturating illegal-instruction count
module control_unit_pipe #(
  parameter int RA_W      = 5,
  parameter bit HAZARD_EN = 1'b1,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_d,
  input  logic                 valid_d,
  input  logic                 stall_e,
  input  logic                 flush_e,
  output logic                 stall_fd,
  output logic                 illegal_d,
  output logic                 valid_e,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 BranchE,
  output logic                 JumpE,
  output logic                 ALUSrcE,
  output logic [1:0]           ResultSrcE,
  output logic [2:0]           ImmSrcE,
  output logic [2:0]           ALUControlE,
  output logic [2:0]           BrTypeE,
  output logic [RA_W-1:0]      RdE,
  output logic [RA_W-1:0]      Rs1E,
  output logic [RA_W-1:0]      Rs2E,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [RA_W-1:0] rd_d, rs1_d, rs2_d;

  assign opcode   = instr_d[6:0];
  assign funct3   = instr_d[14:12];
  assign funct7_5 = instr_d[30];
  assign rd_d     = RA_W'(instr_d[11:7]);
  assign rs1_d    = RA_W'(instr_d[19:15]);
  assign rs2_d    = RA_W'(instr_d[24:20]);

  // funct3 -> ALU operation shared by R and I-ALU; 011 (sltu) is rejected
  // by the legality check, so its value here is irrelevant.
  function automatic logic [2:0] alu_f3(input logic [2:0] f3);
    case (f3)
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      3'b111:  alu_f3 = ALU_AND;
      default: alu_f3 = ALU_ADD;
    endcase
  endfunction

  logic       reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d;
  logic [1:0] result_src_d;
  logic [2:0] imm_src_d, alu_ctrl_d, br_type_d;
  logic       legal_d, uses_rs1, uses_rs2;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    alu_src_d    = 1'b0;
    result_src_d = 2'b00;
    imm_src_d    = 3'b000;
    alu_ctrl_d   = ALU_ADD;
    br_type_d    = 3'b000;
    legal_d      = 1'b0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write_d = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        if (funct7_5) begin
          alu_ctrl_d = ALU_SUB;
          legal_d    = (funct3 == 3'b000);
        end else begin
          alu_ctrl_d = alu_f3(funct3);
          legal_d    = (funct3 != 3'b011);
        end
      end
      OP_I: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        uses_rs1    = 1'b1;
        alu_ctrl_d  = alu_f3(funct3);
        // bit 30 is immediate data except on shifts, where it selects srai
        legal_d     = (funct3 != 3'b011) && !(funct3 == 3'b101 && funct7_5);
      end
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 2'b01;
        uses_rs1     = 1'b1;
        legal_d      = (funct3 == 3'b010);
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src_d   = 3'b001;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        legal_d     = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        branch_d   = 1'b1;
        imm_src_d  = 3'b010;
        alu_ctrl_d = ALU_SUB;
        br_type_d  = funct3;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        legal_d    = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        imm_src_d    = 3'b011;
        result_src_d = 2'b10;
        legal_d      = 1'b1;
      end
      OP_LUI: begin
        reg_write_d  = 1'b1;
        imm_src_d    = 3'b100;
        result_src_d = 2'b11;
        legal_d      = 1'b1;
      end
      default: legal_d = 1'b0;
    endcase
  end

  assign illegal_d = valid_d && !legal_d;

  // Only a load in Execute can produce a result too late to forward.
  logic lu;
  assign lu = HAZARD_EN && valid_d && valid_e && (ResultSrcE == 2'b01) &&
              (RdE != '0) &&
              ((uses_rs1 && (RdE == rs1_d)) || (uses_rs2 && (RdE == rs2_d)));
  assign stall_fd = lu;

  logic bubble;
  assign bubble = flush_e || lu || !valid_d || illegal_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_e     <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ImmSrcE     <= 3'b000;
      ALUControlE <= 3'b000;
      BrTypeE     <= 3'b000;
      RdE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      ill_cnt     <= '0;
    end else begin
      if (!stall_e) begin
        if (bubble) begin
          valid_e     <= 1'b0;
          RegWriteE   <= 1'b0;
          MemWriteE   <= 1'b0;
          BranchE     <= 1'b0;
          JumpE       <= 1'b0;
          ALUSrcE     <= 1'b0;
          ResultSrcE  <= 2'b00;
          ImmSrcE     <= 3'b000;
          ALUControlE <= 3'b000;
          BrTypeE     <= 3'b000;
          RdE         <= '0;
          Rs1E        <= '0;
          Rs2E        <= '0;
        end else begin
          valid_e     <= 1'b1;
          RegWriteE   <= reg_write_d;
          MemWriteE   <= mem_write_d;
          BranchE     <= branch_d;
          JumpE       <= jump_d;
          ALUSrcE     <= alu_src_d;
          ResultSrcE  <= result_src_d;
          ImmSrcE     <= imm_src_d;
          ALUControlE <= alu_ctrl_d;
          BrTypeE     <= br_type_d;
          RdE         <= rd_d;
          Rs1E        <= rs1_d;
          Rs2E        <= rs2_d;
        end
      end
      if (illegal_d && !stall_e && !flush_e && (ill_cnt != '1))
        ill_cnt <= ill_cnt + ILL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_unit_pipe.sv
// Bench for control_unit_pipe: three instances (default, 2-bit counter,
// hazard detection off) share one input stream and are each compared with
// a decode-table reference model.
module tb_control_unit_pipe;

  typedef struct packed {
    logic       valid, rw, mw, br, jp, as;
    logic [1:0] rs;
    logic [2:0] imm, alu, bt;
    logic [4:0] rd, rs1, rs2;
  } ex_t;

  localparam logic [7:0] CMAX [3] = '{8'd255, 8'd3, 8'd255};
  localparam logic       HEN  [3] = '{1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_d = 32'h0;
  logic        valid_d = 1'b0, stall_e = 1'b0, flush_e = 1'b0;

  logic [2:0] sfd, ild, ve, rw, mw, br, jp, as_w;
  logic [1:0] rs_w [3];
  logic [2:0] imm_w [3], alu_w [3], bt_w [3];
  logic [4:0] rd_w [3], r1_w [3], r2_w [3];
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
  ex_t        ex [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  control_unit_pipe u0 (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .stall_fd(sfd[0]), .illegal_d(ild[0]), .valid_e(ve[0]),
    .RegWriteE(rw[0]), .MemWriteE(mw[0]), .BranchE(br[0]), .JumpE(jp[0]),
    .ALUSrcE(as_w[0]), .ResultSrcE(rs_w[0]), .ImmSrcE(imm_w[0]), .ALUControlE(alu_w[0]),
    .BrTypeE(bt_w[0]), .RdE(rd_w[0]), .Rs1E(r1_w[0]), .Rs2E(r2_w[0]), .ill_cnt(cnt0));

  control_unit_pipe #(.ILL_CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .stall_fd(sfd[1]), .illegal_d(ild[1]), .valid_e(ve[1]),
    .RegWriteE(rw[1]), .MemWriteE(mw[1]), .BranchE(br[1]), .JumpE(jp[1]),
    .ALUSrcE(as_w[1]), .ResultSrcE(rs_w[1]), .ImmSrcE(imm_w[1]), .ALUControlE(alu_w[1]),
    .BrTypeE(bt_w[1]), .RdE(rd_w[1]), .Rs1E(r1_w[1]), .Rs2E(r2_w[1]), .ill_cnt(cnt1));

  control_unit_pipe #(.HAZARD_EN(1'b0)) u2 (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .stall_fd(sfd[2]), .illegal_d(ild[2]), .valid_e(ve[2]),
    .RegWriteE(rw[2]), .MemWriteE(mw[2]), .BranchE(br[2]), .JumpE(jp[2]),
    .ALUSrcE(as_w[2]), .ResultSrcE(rs_w[2]), .ImmSrcE(imm_w[2]), .ALUControlE(alu_w[2]),
    .BrTypeE(bt_w[2]), .RdE(rd_w[2]), .Rs1E(r1_w[2]), .Rs2E(r2_w[2]), .ill_cnt(cnt2));

  for (genvar g = 0; g < 3; g++) begin : g_pack
    assign ex[g] = {ve[g], rw[g], mw[g], br[g], jp[g], as_w[g], rs_w[g], imm_w[g],
                    alu_w[g], bt_w[g], rd_w[g], r1_w[g], r2_w[g]};
  end

  // ---------------- reference model ----------------
  ex_t        m  [3] = '{default: '0};
  logic [7:0] mc [3] = '{default: 8'd0};

  function automatic logic [2:0] alu_of(input logic [2:0] f3);
    case (f3)
      3'd1: return 3'd6;  // sll
      3'd2: return 3'd5;  // slt
      3'd4: return 3'd4;  // xor
      3'd5: return 3'd7;  // srl
      3'd6: return 3'd3;  // or
      3'd7: return 3'd2;  // and
      default: return 3'd0;
    endcase
  endfunction

  // Decode table: returns the E control word an accepted instruction would load.
  function automatic ex_t dec(input logic [31:0] i, output logic legal,
                              output logic u1, output logic u2);
    ex_t e;
    logic [2:0] f3;
    logic hi;
    e = '0; legal = 1'b0; u1 = 1'b0; u2 = 1'b0;
    f3 = i[14:12]; hi = i[30];
    e.valid = 1'b1; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    case (i[6:0])
      7'h33: begin e.rw = 1; u1 = 1; u2 = 1;
        e.alu = (hi && f3 == 3'd0) ? 3'd1 : alu_of(f3);
        legal = hi ? (f3 == 3'd0) : (f3 != 3'd3); end
      7'h13: begin e.rw = 1; e.as = 1; u1 = 1; e.alu = alu_of(f3);
        legal = (f3 != 3'd3) && !(f3 == 3'd5 && hi); end
      7'h03: begin e.rw = 1; e.as = 1; e.rs = 2'b01; u1 = 1; legal = (f3 == 3'd2); end
      7'h23: begin e.mw = 1; e.as = 1; e.imm = 3'd1; u1 = 1; u2 = 1; legal = (f3 == 3'd2); end
      7'h63: begin e.br = 1; e.imm = 3'd2; e.alu = 3'd1; e.bt = f3; u1 = 1; u2 = 1;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5); end
      7'h6F: begin e.rw = 1; e.jp = 1; e.imm = 3'd3; e.rs = 2'b10; legal = 1; end
      7'h37: begin e.rw = 1; e.imm = 3'd4; e.rs = 2'b11; legal = 1; end
      default: legal = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic exp_lu(input int k);
    logic lg, u1, u2;
    ex_t d;
    d = dec(instr_d, lg, u1, u2);
    return HEN[k] && valid_d && m[k].valid && (m[k].rs == 2'b01) && (m[k].rd != 5'd0) &&
           ((u1 && m[k].rd == instr_d[19:15]) || (u2 && m[k].rd == instr_d[24:20]));
  endfunction

  function automatic logic exp_ill();
    logic lg, u1, u2;
    ex_t d;
    d = dec(instr_d, lg, u1, u2);
    return valid_d && !lg;
  endfunction

  always @(posedge clk) begin : model
    logic lg, u1, u2, lu;
    ex_t d;
    for (int k = 0; k < 3; k++) begin
      d  = dec(instr_d, lg, u1, u2);
      lu = exp_lu(k);
      if (!rst) begin
        m[k]  <= '0;
        mc[k] <= 8'd0;
      end else begin
        if (!stall_e) m[k] <= (flush_e || lu || !valid_d || !lg) ? '0 : d;
        if (valid_d && !lg && !stall_e && !flush_e && mc[k] < CMAX[k]) mc[k] <= mc[k] + 8'd1;
      end
    end
  end

  function automatic logic [7:0] dut_cnt(input int k);
    if (k == 0) return cnt0;
    if (k == 1) return {6'd0, cnt1};
    return cnt2;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
    instr_d = i; valid_d = v; stall_e = s; flush_e = f;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 9))
      0, 1: i[6:0] = 7'h33;
      2:    i[6:0] = 7'h13;
      3, 4: i[6:0] = 7'h03;
      5:    i[6:0] = 7'h23;
      6:    i[6:0] = 7'h63;
      7:    i[6:0] = 7'h6F;
      8:    i[6:0] = 7'h37;
      default: ;
    endcase
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    if ((i[6:0] == 7'h03 || i[6:0] == 7'h23) && $urandom_range(0, 1) == 1) i[14:12] = 3'b010;
    if (i[6:0] == 7'h33 && $urandom_range(0, 2) != 0) i[30] = 1'b0;
    return i;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive($urandom, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      tick();
      nvec++;
      if (ex[0] !== '0) begin $display("FAIL reset_ex: got %h want 0", ex[0]); nerr++; end
      nvec++;
      if (cnt0 !== 8'd0) begin $display("FAIL reset_cnt: got %0d want 0", cnt0); nerr++; end
    end
    rst = 1'b1;
    drive(32'h002081B3, 1'b1, 1'b0, 1'b0);  // add x3,x1,x2
    tick();
    nvec++;
    if ({ve[0], rw[0], alu_w[0], rd_w[0], r1_w[0], r2_w[0]} !== {1'b1, 1'b1, 3'd0, 5'd3, 5'd1, 5'd2}) begin
      $display("FAIL add_decode: got v=%b rw=%b alu=%0d rd=%0d rs1=%0d rs2=%0d want 1 1 0 3 1 2",
               ve[0], rw[0], alu_w[0], rd_w[0], r1_w[0], r2_w[0]);
      nerr++;
    end
    nvec++;
    if (ex[0] !== m[0]) begin $display("FAIL add_model: got %h want %h", ex[0], m[0]); nerr++; end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    drive(32'h0000A283, 1'b1, 1'b0, 1'b0);  // lw x5,0(x1)
    tick();
    drive(32'h00728333, 1'b1, 1'b0, 1'b0);  // add x6,x5,x7
    #2;
    if (sfd[0]) stalls++;
    nvec++;
    if (sfd[2] !== 1'b0) begin $display("FAIL lu_hen0_stall: got %b want 0", sfd[2]); nerr++; end
    tick();
    nvec++;
    if (ve[0] !== 1'b0) begin $display("FAIL lu_bubble: valid_e got %b want 0", ve[0]); nerr++; end
    nvec++;
    if (ve[2] !== 1'b1 || r1_w[2] !== 5'd5) begin
      $display("FAIL lu_hen0_nobubble: valid_e got %b rs1 %0d want 1 5", ve[2], r1_w[2]); nerr++;
    end
    #2;
    if (sfd[0]) stalls++;
    tick();
    nvec++;
    if (stalls !== 1) begin $display("FAIL lu_stall_len: got %0d cycles want 1", stalls); nerr++; end
    nvec++;
    if (ve[0] !== 1'b1 || r1_w[0] !== 5'd5 || rd_w[0] !== 5'd6) begin
      $display("FAIL lu_release: valid_e %b rs1 %0d rd %0d want 1 5 6", ve[0], r1_w[0], rd_w[0]); nerr++;
    end
    drive(32'h0000A003, 1'b1, 1'b0, 1'b0);  // lw x0,0(x1)
    tick();
    drive(32'h00000333, 1'b1, 1'b0, 1'b0);  // add x6,x0,x0
    #2;
    nvec++;
    if (sfd[0] !== 1'b0) begin $display("FAIL lu_rd0: stall_fd got %b want 0", sfd[0]); nerr++; end
    tick();
    nvec++;
    if (ex[0] !== m[0]) begin $display("FAIL lu_rd0_model: got %h want %h", ex[0], m[0]); nerr++; end
  endtask

  task automatic test_stall_flush();
    ex_t beq_e;
    logic lg, u1, u2;
    beq_e = dec(32'h00208063, lg, u1, u2);  // beq x1,x2,0
    drive(32'h00208063, 1'b1, 1'b0, 1'b0);
    tick();
    nvec++;
    if (br[0] !== 1'b1 || ex[0] !== beq_e) begin $display("FAIL beq_load: got %h want %h", ex[0], beq_e); nerr++; end
    for (int c = 0; c < 4; c++) begin
      drive(rand_instr(), 1'($urandom_range(0, 1)), 1'b1, 1'(c == 3));
      tick();
      nvec++;
      if (ex[0] !== beq_e) begin $display("FAIL stall_hold_%0d: got %h want %h", c, ex[0], beq_e); nerr++; end
    end
    drive(32'h002081B3, 1'b1, 1'b0, 1'b1);
    tick();
    nvec++;
    if (br[0] !== 1'b0 || ve[0] !== 1'b0) begin
      $display("FAIL flush: BranchE %b valid_e %b want 0 0", br[0], ve[0]); nerr++;
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ill [5] = '{32'h00000073, 32'h003130B3, 32'h40315093, 32'h0000D0FF, 32'h0020C0B3 | 32'h40000000};
    nvec++;
    if (cnt0 !== 8'd0) begin $display("FAIL ill_start: got %0d want 0", cnt0); nerr++; end
    for (int n = 0; n < 5; n++) begin
      drive(ill[n], 1'b1, 1'b0, 1'b0);
      #2;
      nvec++;
      if (ild[0] !== 1'b1) begin $display("FAIL ill_flag_%0d: got %b want 1", n, ild[0]); nerr++; end
      tick();
      nvec++;
      if (ve[0] !== 1'b0 || cnt0 !== 8'(n + 1)) begin
        $display("FAIL ill_cnt_%0d: valid_e %b cnt %0d want 0 %0d", n, ve[0], cnt0, n + 1); nerr++;
      end
    end
    nvec++;
    if (cnt1 !== 2'd3) begin $display("FAIL ill_saturate: got %0d want 3", cnt1); nerr++; end
  endtask

  task automatic test_full_map();
    logic [6:0] ops [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};
    logic [31:0] i;
    logic lg, u1, u2;
    ex_t d;
    for (int o = 0; o < 7; o++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int hi = 0; hi < 2; hi++) begin
          i = $urandom;
          i[6:0] = ops[o]; i[14:12] = 3'(f3); i[30] = 1'(hi);
          d = dec(i, lg, u1, u2);
          if (lg) begin
            drive(i, 1'b1, 1'b0, 1'b0);
            tick();
            nvec++;
            if (ex[0] !== m[0]) begin $display("FAIL map_%h: got %h want %h", i, ex[0], m[0]); nerr++; end
            if (ops[o] == 7'h6F) begin
              nvec++;
              if (rs_w[0] !== 2'b10 || jp[0] !== 1'b1) begin
                $display("FAIL jal: ResultSrcE %b JumpE %b want 10 1", rs_w[0], jp[0]); nerr++;
              end
            end
            if (ops[o] == 7'h37) begin
              nvec++;
              if (rs_w[0] !== 2'b11 || imm_w[0] !== 3'b100) begin
                $display("FAIL lui: ResultSrcE %b ImmSrcE %b want 11 100", rs_w[0], imm_w[0]); nerr++;
              end
            end
            drive($urandom, 1'b0, 1'b0, 1'b0);
            tick();
          end
        end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) != 0);
      drive(rand_instr(), 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 6) == 0));
      #2;
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (sfd[k] !== exp_lu(k) || ild[k] !== exp_ill()) begin
          $display("FAIL rnd_comb_%0d_%0d: stall_fd %b illegal %b want %b %b",
                   k, c, sfd[k], ild[k], exp_lu(k), exp_ill());
          nerr++;
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (ex[k] !== m[k] || dut_cnt(k) !== mc[k]) begin
          $display("FAIL rnd_reg_%0d_%0d: got %h cnt %0d want %h cnt %0d",
                   k, c, ex[k], dut_cnt(k), m[k], mc[k]);
          nerr++;
        end
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h002081B3, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(32'h00000073, 1'b1, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (ex[k] !== '0 || dut_cnt(k) !== 8'd0) begin
        $display("FAIL rst_mid_stall_%0d: got %h cnt %0d want 0 0", k, ex[k], dut_cnt(k)); nerr++;
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_stall_flush();
    test_illegal();
    test_full_map();
    test_random();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Next-generation control unit for the pipelined RV32I core.
- Decodes the Decode-stage instruction and registers all control fields into the Decode/Execute (ID/EX) pipeline register.
- Adds features the previous unit lacks: stall, flush and bubble insertion, load-use hazard detection, extended opcode and branch coverage, and illegal-instruction flagging with a counter.
- Sits between the IF/ID register and the Execute stage; replaces the combinational control path plus the ID/EX control register.

Parameters:
- RA_W, 5, register-address width for the rd/rs1/rs2 fields.
- HAZARD_EN, 1, 1 enables load-use detection; 0 forces stall_fd to 0.
- ILL_CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- instr_d  in  32  Decode-stage instruction.
- valid_d  in  1  instr_d holds a real instruction.
- stall_e  in  1  hold the ID/EX register.
- flush_e  in  1  load a bubble into ID/EX (taken branch or jump).
- stall_fd  out  1  combinational: load-use stall request to IF/ID.
- illegal_d  out  1  combinational: valid_d and instr_d not supported.
- valid_e  out  1  Execute slot holds a real instruction.
- RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE  out  1 each  registered controls.
- ResultSrcE  out  2  registered: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
- ImmSrcE  out  3  registered: 000 I, 001 S, 010 B, 011 J, 100 U.
- ALUControlE  out  3  registered: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- BrTypeE  out  3  registered funct3 of the branch.
- RdE, Rs1E, Rs2E  out  RA_W  registered register fields.
- ill_cnt  out  ILL_CNT_W  saturating illegal-instruction count.

Behaviour:
- Decode, combinational in D:
  - R 0110011: RegWrite; ALU function from funct3 plus funct7[5]. Only funct7[5]=1 with funct3=000 (sub) is legal; funct3=011 (sltu) and funct7[5]=1 on 101 (sra) are illegal.
  - I-ALU 0010011: RegWrite, ALUSrc, ImmSrc=I. Same funct3 map, no sub. srai and sltiu are illegal.
  - load 0000011: RegWrite, ALUSrc, ResultSrc=01, add. Only funct3=010 is legal.
  - store 0100011: MemWrite, ALUSrc, ImmSrc=S, add. Only funct3=010 is legal.
  - branch 1100011: Branch, ImmSrc=B, sub, BrType=funct3. Legal funct3: 000, 001, 100, 101.
  - jal 1101111: RegWrite, Jump, ImmSrc=J, ResultSrc=10.
  - lui 0110111: RegWrite, ImmSrc=U, ResultSrc=11.
  - Any other opcode is illegal.
- Register usage:
  - rs1 used by R, I-ALU, load, store, branch.
  - rs2 used by R, store, branch.
- Load-use hazard, lu = HAZARD_EN & valid_d & valid_e & ResultSrcE==01 & RdE!=0 & ((uses_rs1 & RdE==rs1_d) | (uses_rs2 & RdE==rs2_d)). stall_fd = lu.
- ID/EX register update, priority order:
  1. !rst: all registered outputs 0, ill_cnt=0.
  2. stall_e: hold every registered output.
  3. flush_e | lu | !valid_d | illegal_d: bubble. valid_e=0, all controls and register fields 0.
  4. Otherwise: load the decoded fields and set valid_e=1.
- A bubble never writes a register or memory. Zeroed fields guarantee RegWriteE=MemWriteE=BranchE=JumpE=0.
- ill_cnt increments by 1 when illegal_d & !stall_e & !flush_e. It saturates at all-ones and never wraps.
- stall_fd is held while lu persists. When the load leaves E, the next edge loads the dependent instruction normally, so latency is exactly one bubble.
- Simultaneous flush_e and lu: flush wins and a bubble is inserted. stall_fd is still asserted that cycle; the IF/ID flush overrides it externally.
- Reset asserted mid-stall: reset wins on that edge.
- Latency: decoded controls appear on the E outputs one clock after valid_d is sampled.

Test Plan:
- Reset and independent decode:
  - Hold rst=0 for 2 clocks with random instr_d; all outputs must be 0 and ill_cnt=0.
  - Release reset; apply add x3,x1,x2 (0x002081B3) with valid_d=1.
  - Next cycle must show valid_e=1, RegWriteE=1, ALUControlE=000, RdE=3, Rs1E=1, Rs2E=2.
- Load-use:
  - Apply lw x5,0(x1), then add x6,x5,x7.
  - stall_fd=1 for exactly one cycle, with valid_e=0 after the bubble.
  - Then add reaches E with Rs1E=5; RdE=0 load (lw x0) must not stall.
- Stall and flush:
  - Hold stall_e=1 for 3 cycles with beq in E; E outputs stay constant.
  - Assert flush_e together with stall_e; the hold must win.
  - Then flush_e alone produces BranchE=0, valid_e=0.
- Illegal:
  - Apply opcode 1110011, sltu and srai.
  - Each sets illegal_d=1 and inserts a bubble; ill_cnt goes 0→1→2→3.
  - With ILL_CNT_W=2 and 5 illegal instructions, ill_cnt must stick at 3.
- Full map:
  - Sweep every legal opcode/funct3/funct7 combination and check all E fields against the decode table.
  - jal must give ResultSrcE=10, JumpE=1; lui must give ResultSrcE=11, ImmSrcE=100.
- HAZARD_EN=0: rerun the load-use scenario; stall_fd must stay 0 and no bubble may be inserted.
